aurora_tx_framer: RTL and testbench

AURORA_TX_FRAMER -- requirements
Module: aurora_tx_framer

---
 rtl/aurora_tx_pkg.sv | 30 +++
 rtl/aurora_tx_skid.sv | 45 ++++
 rtl/aurora_tx_framer.sv | 176 +++++++++++++++++
 tb/tb_aurora_tx_framer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_tx_pkg.sv
// Shared definitions for the Aurora TX framer: FSM encoding, header layout, CRC-32 constants/step.
// CRC items are only referenced when AURORA_TX_CRC_EN is defined.
package aurora_tx_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HDR     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_TRL     = 2'd3;

  // Header word layout, MSB first: tag[31:16], seq[15:8], len[7:0].
  typedef struct packed {
    logic [15:0] tag;
    logic [7:0]  seq;
    logic [7:0]  len;
  } hdr_t;

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  // One 32-bit word through the CRC register, MSB of the data first, no reflection.
  function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] dat);
    logic [31:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      c = {c[30:0], 1'b0} ^ ((c[31] ^ dat[i]) ? CRC_POLY : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/aurora_tx_skid.sv
// Two-entry buffer between the FIFO read port and the LocalLink output; 1-cycle push-to-head latency.
// No internal backpressure: the framer only reads when occupancy plus in-flight reads leaves room.
module aurora_tx_skid
  import aurora_tx_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_push,
  input  logic [31:0] i_dat,
  input  logic        i_pop,
  output logic        o_vld,
  output logic [31:0] o_dat,
  output logic [1:0]  o_cnt
);

  logic [31:0] r_mem [2];
  logic        r_wptr;
  logic        r_rptr;
  logic [1:0]  r_cnt;
  logic        w_pop;

  assign w_pop = i_pop && (r_cnt != 2'd0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_dat;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

  assign o_vld = (r_cnt != 2'd0);
  assign o_dat = r_mem[r_rptr];
  assign o_cnt = r_cnt;

endmodule

// File: rtl/aurora_tx_framer.sv
// Frames prefetch-FIFO words as header + len payload words (+ CRC-32 trailer with AURORA_TX_CRC_EN) onto LocalLink.
// 1 word/cycle under continuous ready; tx_dst_rdy_n_i=1 freezes the output beat and throttles FIFO reads.
module aurora_tx_framer
  import aurora_tx_pkg::*;
#(
  parameter int          PKT_WORDS   = 64,
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [15:0] HDR_TAG     = 16'hA5C3
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [31:0] fifo_dat_i,
  input  logic        fifo_empty_i,
  input  logic [17:0] fifo_cnt_i,
  output logic        fifo_rd_o,
  output logic [31:0] tx_d_o,
  output logic        tx_src_rdy_n_o,
  output logic        tx_sof_n_o,
  output logic        tx_eof_n_o,
  input  logic        tx_dst_rdy_n_i,
  output logic        busy_o
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]      r_state;
  logic [7:0]      r_seq;
  logic [7:0]      r_len;
  logic [7:0]      r_out_left;
  logic [7:0]      r_rd_left;
  logic [TO_W-1:0] r_to;
  logic            r_inflight;
`ifdef AURORA_TX_CRC_EN
  logic [31:0]     r_crc;
`endif

  logic [7:0]  w_cnt8;
  logic [7:0]  w_len;
  logic        w_start;
  logic        w_xfer;
  logic        w_pop;
  logic        w_last;
  logic        w_space;
  logic        w_rd;
  logic        w_sk_vld;
  logic [31:0] w_sk_dat;
  logic [1:0]  w_sk_cnt;
  hdr_t        w_hdr;
  logic        w_unused_cnt;

  // Occupancy above 255 is outside the framer's view.
  assign w_unused_cnt = ^fifo_cnt_i[17:8];

  assign w_cnt8  = fifo_cnt_i[7:0];
  assign w_len   = (w_cnt8 >= 8'(PKT_WORDS)) ? 8'(PKT_WORDS) : w_cnt8;
  assign w_start = (r_state == ST_IDLE) &&
                   ((w_cnt8 >= 8'(PKT_WORDS)) || ((r_to == TO_W'(TIMEOUT_CYC)) && (w_cnt8 != 8'd0)));
  assign w_xfer  = !tx_src_rdy_n_o && !tx_dst_rdy_n_i;
  assign w_pop   = (r_state == ST_PAYLOAD) && w_xfer;
  assign w_last  = (r_out_left == 8'd1);
  // A word popped this cycle frees its slot in time for a read issued now.
  assign w_space = ({1'b0, w_sk_cnt} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop});
  assign w_rd    = reset_n_i && !fifo_empty_i && w_space &&
                   (w_start || ((r_state != ST_IDLE) && (r_rd_left != 8'd0)));
  assign fifo_rd_o = w_rd;

  aurora_tx_skid u_skid (
    .i_clk   (clk_i),
    .i_rst_n (reset_n_i),
    .i_push  (r_inflight),
    .i_dat   (fifo_dat_i),
    .i_pop   (w_pop),
    .o_vld   (w_sk_vld),
    .o_dat   (w_sk_dat),
    .o_cnt   (w_sk_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state    <= ST_IDLE;
      r_seq      <= 8'd0;
      r_len      <= 8'd0;
      r_out_left <= 8'd0;
      r_rd_left  <= 8'd0;
      r_to       <= '0;
      r_inflight <= 1'b0;
`ifdef AURORA_TX_CRC_EN
      r_crc      <= CRC_INIT;
`endif
    end else begin
      r_inflight <= w_rd;

      if (w_start)   r_rd_left <= w_len - {7'd0, w_rd};
      else if (w_rd) r_rd_left <= r_rd_left - 8'd1;

      if ((r_state == ST_IDLE) && (w_cnt8 != 8'd0) && (w_cnt8 < 8'(PKT_WORDS))) begin
        if (r_to != TO_W'(TIMEOUT_CYC)) r_to <= r_to + 1'b1;
      end else begin
        r_to <= '0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state    <= ST_HDR;
            r_len      <= w_len;
            r_out_left <= w_len;
`ifdef AURORA_TX_CRC_EN
            r_crc      <= CRC_INIT;
`endif
          end
        end
        ST_HDR: begin
          if (w_xfer) r_state <= ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          if (w_xfer) begin
            r_out_left <= r_out_left - 8'd1;
`ifdef AURORA_TX_CRC_EN
            r_crc <= crc32_word(r_crc, w_sk_dat);
            if (w_last) r_state <= ST_TRL;
`else
            if (w_last) begin
              r_state <= ST_IDLE;
              r_seq   <= r_seq + 8'd1;
            end
`endif
          end
        end
`ifdef AURORA_TX_CRC_EN
        ST_TRL: begin
          if (w_xfer) begin
            r_state <= ST_IDLE;
            r_seq   <= r_seq + 8'd1;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_hdr = '{tag: HDR_TAG, seq: r_seq, len: r_len};

  always_comb begin
    tx_d_o         = 32'h0;
    tx_src_rdy_n_o = 1'b1;
    tx_sof_n_o     = 1'b1;
    tx_eof_n_o     = 1'b1;
    case (r_state)
      ST_HDR: begin
        tx_d_o         = w_hdr;
        tx_src_rdy_n_o = 1'b0;
        tx_sof_n_o     = 1'b0;
      end
      ST_PAYLOAD: begin
        tx_d_o         = w_sk_dat;
        tx_src_rdy_n_o = !w_sk_vld;
`ifndef AURORA_TX_CRC_EN
        tx_eof_n_o     = !(w_sk_vld && w_last);
`endif
      end
`ifdef AURORA_TX_CRC_EN
      ST_TRL: begin
        tx_d_o         = r_crc;
        tx_src_rdy_n_o = 1'b0;
        tx_eof_n_o     = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  assign busy_o = (r_state != ST_IDLE);

endmodule

// File: tb/tb_aurora_tx_framer.sv
// Directed bench for aurora_tx_framer with a behavioural prefetch FIFO; honours AURORA_TX_CRC_EN.
module tb_aurora_tx_framer;

`ifdef AURORA_TX_CRC_EN
  localparam int TRL_W = 1;
`else
  localparam int TRL_W = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] fifo_dat;
  logic        fifo_empty;
  logic [17:0] fifo_cnt;
  logic        fifo_rd;
  logic [31:0] tx_d;
  logic        src_n, sof_n, eof_n, dst_n, busy;

  always #5 clk = ~clk;

  aurora_tx_framer dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .fifo_dat_i     (fifo_dat),
    .fifo_empty_i   (fifo_empty),
    .fifo_cnt_i     (fifo_cnt),
    .fifo_rd_o      (fifo_rd),
    .tx_d_o         (tx_d),
    .tx_src_rdy_n_o (src_n),
    .tx_sof_n_o     (sof_n),
    .tx_eof_n_o     (eof_n),
    .tx_dst_rdy_n_i (dst_n),
    .busy_o         (busy)
  );

  int          total = 0;
  int          bad = 0;
  logic [31:0] q[$];
  logic [31:0] exp_q[$];
  logic [31:0] b_d[$];
  logic        b_sof[$];
  logic        b_eof[$];
  int          b_cyc[$];
  int          cyc = 0;
  bit          rnd_en = 1'b0;
  bit          frame_end = 1'b0;
  int          rd_err = 0;
  int          stab_err = 0;
  logic        p_stall = 1'b0;
  logic [34:0] p_out = '0;
  logic [31:0] last_hdr = '0;
  logic [31:0] prev_hdr = '0;
  int          s = 0;
  int          lens[10] = '{64, 1, 64, 3, 64, 64, 2, 64, 64, 64};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

`ifdef AURORA_TX_CRC_EN
  function automatic logic [31:0] crc_model(input logic [31:0] c_in, input logic [31:0] d);
    logic [31:0] c;
    logic        msb;
    c = c_in;
    for (int i = 31; i >= 0; i--) begin
      msb = c[31];
      c   = c << 1;
      if (msb ^ d[i]) c = c ^ 32'h04C11DB7;
    end
    return c;
  endfunction
`endif

  task automatic fifo_flags();
    fifo_cnt   = 18'(q.size());
    fifo_empty = (q.size() == 0);
  endtask

  // One clock: inputs are set at the falling edge, sampled 1 ns later, FIFO updated after the rising edge.
  task automatic cycle();
    logic rd;
    if (rnd_en) dst_n = 1'($urandom_range(0, 1));
    #1;
    if (p_stall && (p_out !== {tx_d, src_n, sof_n, eof_n})) stab_err++;
    p_stall = reset_n && !src_n && dst_n;
    p_out   = {tx_d, src_n, sof_n, eof_n};
    if (reset_n && !src_n && !dst_n) begin
      b_d.push_back(tx_d);
      b_sof.push_back(sof_n);
      b_eof.push_back(eof_n);
      b_cyc.push_back(cyc);
      if (!eof_n) frame_end = 1'b1;
    end
    rd = fifo_rd;
    @(posedge clk);
    #1;
    cyc++;
    if (rd) begin
      if (q.size() == 0) rd_err++;
      else fifo_dat = q.pop_front();
    end
    fifo_flags();
    @(negedge clk);
  endtask

  task automatic push_words(input int n, input logic [31:0] base, input logic [31:0] inc);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = base + inc * 32'(i);
      q.push_back(w);
      exp_q.push_back(w);
    end
    fifo_flags();
  endtask

  task automatic push_rand(input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      q.push_back(w);
      exp_q.push_back(w);
    end
    fifo_flags();
  endtask

  task automatic clear_beats();
    b_d.delete();
    b_sof.delete();
    b_eof.delete();
    b_cyc.delete();
  endtask

  task automatic run_frame(input int bound);
    frame_end = 1'b0;
    for (int i = 0; i < bound && !frame_end; i++) cycle();
    chk("frame_done", 32'(frame_end), 32'd1);
  endtask

  task automatic check_frame(input int seq, input int len);
    int          n;
    int          errs;
    logic [31:0] w;
    logic [31:0] crc;
    n   = len + 1 + TRL_W;
    crc = 32'hFFFFFFFF;
    chk("beat_count", 32'(b_d.size()), 32'(n));
    if (b_d.size() == n) begin
      prev_hdr = last_hdr;
      last_hdr = b_d[0];
      chk("header", b_d[0], {16'hA5C3, 8'(seq), 8'(len)});
      errs = 0;
      for (int i = 0; i < n; i++) begin
        if (b_sof[i] !== (i != 0)) errs++;
        if (b_eof[i] !== (i != n - 1)) errs++;
      end
      chk("sof_eof_marks", 32'(errs), 32'd0);
      errs = 0;
      for (int i = 1; i <= len; i++) begin
        w = exp_q.pop_front();
        if (b_d[i] !== w) errs++;
`ifdef AURORA_TX_CRC_EN
        crc = crc_model(crc, w);
`endif
      end
      chk("payload_order", 32'(errs), 32'd0);
`ifdef AURORA_TX_CRC_EN
      chk("crc_trailer", b_d[n-1], crc);
`endif
    end else begin
      for (int i = 0; i < len && exp_q.size() > 0; i++) void'(exp_q.pop_front());
    end
    clear_beats();
  endtask

  initial begin
    reset_n    = 1'b0;
    dst_n      = 1'b0;
    fifo_dat   = 32'h0;
    fifo_empty = 1'b1;
    fifo_cnt   = 18'd0;
    @(negedge clk);
    cycle();
    cycle();
    #1;
    chk("rst_src_rdy_n", 32'(src_n), 32'd1);
    chk("rst_sof_n", 32'(sof_n), 32'd1);
    chk("rst_eof_n", 32'(eof_n), 32'd1);
    chk("rst_tx_d", tx_d, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    reset_n = 1'b1;

    // Full 64-word frame with ready held low
    push_words(64, 32'h1000_0000, 32'd1);
    run_frame(200);
    if (b_d.size() > 0) begin
      chk("hdr_full_frame", b_d[0], 32'hA5C30040);
      chk("consecutive_beats", 32'(b_cyc[b_cyc.size()-1] - b_cyc[0]), 32'(64 + TRL_W));
    end
    check_frame(0, 64);
    s = 1;
    cycle();
    chk("idle_after_frame", 32'(busy), 32'd0);

    // 5 words below threshold: nothing until the idle timeout expires
    push_words(5, 32'h2000_0000, 32'd1);
    for (int i = 0; i < 1024; i++) cycle();
    chk("no_frame_before_timeout", 32'(b_d.size()), 32'd0);
    run_frame(50);
    check_frame(s, 5);
    s++;

    // Reset while payload word 10 is on the bus
    push_words(64, 32'h3000_0000, 32'd1);
    frame_end = 1'b0;
    for (int i = 0; i < 200 && b_d.size() < 10; i++) cycle();
    chk("reached_word10", 32'(b_d.size()), 32'd10);
    chk("word10_on_bus", tx_d, 32'h3000_0009);
    reset_n = 1'b0;
    cycle();
    q.delete();
    exp_q.delete();
    fifo_flags();
    chk("no_eof_before_reset", 32'(frame_end), 32'd0);
    clear_beats();
    reset_n = 1'b1;
    p_stall = 1'b0;
    #1;
    chk("midrst_src_rdy_n", 32'(src_n), 32'd1);
    chk("midrst_sof_n", 32'(sof_n), 32'd1);
    chk("midrst_eof_n", 32'(eof_n), 32'd1);
    chk("midrst_tx_d", tx_d, 32'h0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_fifo_rd", 32'(fifo_rd), 32'd0);
    s = 0;

    // 10 frames of random data under 50% random backpressure, seq restarting at 0
    rnd_en = 1'b1;
    for (int f = 0; f < 10; f++) begin
      push_rand(lens[f]);
      run_frame((lens[f] < 64) ? 1300 : 600);
      check_frame(s, lens[f]);
      s++;
    end
    rnd_en = 1'b0;
    dst_n  = 1'b0;
    chk("stable_while_not_ready", 32'(stab_err), 32'd0);

`ifdef AURORA_TX_CRC_EN
    push_words(4, 32'h0000_0001, 32'd0);
    run_frame(1300);
    check_frame(s, 4);
    s++;
`endif

    // Run frames until the sequence number wraps 255 -> 0
    for (int f = s; f <= 256; f++) begin
      push_words(64, 32'(f) << 8, 32'd1);
      run_frame(200);
      check_frame(f % 256, 64);
    end
    chk("seq_before_wrap", 32'(prev_hdr[15:8]), 32'hFF);
    chk("seq_wrapped", 32'(last_hdr[15:8]), 32'h00);
    chk("no_read_when_empty", 32'(rd_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
